// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for immediate decoding: opcode values and the
// immediate format codes presented on the pipeline output.
package riscv_pkg;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtSh   = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] F3Sll = 3'b001;
  localparam logic [2:0] F3Srx = 3'b101;

  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3Sll) || (funct3 == F3Srx);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extractor: instruction word to sign-extended
// immediate, format code and an illegal-opcode flag.
module imm_decode
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_raw;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];

  // Every immediate fits in 32 signed bits; shift amounts keep bit 31 clear
  // so the common sign extension below leaves them zero-extended.
  always_comb begin
    w_raw     = '0;
    o_fmt     = FmtNone;
    o_illegal = 1'b0;
    case (w_opcode)
      OpLoad, OpJalr: begin
        o_fmt = FmtI;
        w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OpImm, OpImm32: begin
        if (is_shift(w_funct3)) begin
          o_fmt = FmtSh;
          if ((XLEN == 64) && (w_opcode == OpImm)) begin
            w_raw = {26'b0, i_instr[25:20]};
          end else begin
            w_raw = {27'b0, i_instr[24:20]};
          end
        end else begin
          o_fmt = FmtI;
          w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
        end
      end
      OpStore: begin
        o_fmt = FmtS;
        w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OpBranch: begin
        o_fmt = FmtB;
        w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                 i_instr[11:8], 1'b0};
      end
      OpLui, OpAuipc: begin
        o_fmt = FmtU;
        w_raw = {i_instr[31:12], 12'b0};
      end
      OpJal: begin
        o_fmt = FmtJ;
        w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                 i_instr[30:21], 1'b0};
      end
      OpReg: begin
        o_fmt = FmtNone;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_imm = XLEN'($signed(w_raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Single-stage immediate generator with valid/ready handshakes on both sides:
// one output register backed by a one-entry skid buffer.
module imm_gen_pipe
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t r_out, r_skid;
  logic   r_out_valid, r_skid_valid, r_in_ready;

  entry_t w_dec, w_out_d, w_skid_d;
  logic   w_out_valid_d, w_skid_valid_d;
  logic   w_in_xfer, w_out_free;

  imm_decode #(
    .XLEN(XLEN)
  ) u_imm_decode (
    .i_instr  (in_instr),
    .o_imm    (w_dec.imm),
    .o_fmt    (w_dec.fmt),
    .o_illegal(w_dec.illegal)
  );

  assign w_dec.tag  = in_tag;
  assign w_in_xfer  = in_valid & r_in_ready;
  // Output register can take a new entry this edge if empty or draining.
  assign w_out_free = !r_out_valid || out_ready;

  always_comb begin
    w_out_d        = r_out;
    w_out_valid_d  = r_out_valid;
    w_skid_d       = r_skid;
    w_skid_valid_d = r_skid_valid;
    if (w_out_free) begin
      if (r_skid_valid) begin
        w_out_d        = r_skid;
        w_out_valid_d  = 1'b1;
        w_skid_valid_d = 1'b0;
      end else if (w_in_xfer) begin
        w_out_d       = w_dec;
        w_out_valid_d = 1'b1;
      end else begin
        w_out_valid_d = 1'b0;
      end
    end else if (w_in_xfer) begin
      w_skid_d       = w_dec;
      w_skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_out        <= w_out_d;
      r_skid       <= w_skid_d;
      r_out_valid  <= w_out_valid_d;
      r_skid_valid <= w_skid_valid_d;
      r_in_ready   <= !w_skid_valid_d;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.illegal;
  assign out_tag     = r_out.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a driver pushes expected results on each
// accepted word, a negedge monitor pops and compares on each output transfer.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_valid, out_ready;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic [7:0]  out_tag;

  logic        v32, rdy32, ov32, ordy32, ill32;
  logic [31:0] instr32, imm32;
  logic [7:0]  tag32, otag32;
  logic [2:0]  fmt32;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
    .in_instr(instr32), .in_tag(tag32), .out_valid(ov32), .out_ready(ordy32),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(otag32)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t prev, mon_e;
  logic have_prev = 1'b0;
  logic stale_watch = 1'b0;
  logic [7:0] stale_a = 8'h00, stale_b = 8'h00;
  int checks = 0, failures = 0;

  // Directed vectors, hand-decoded.
  logic [31:0] v_instr [12] = '{32'hFE000EE3, 32'h123452B7, 32'h03F09093, 32'h4030D093,
                                32'hFE112E23, 32'h008000EF, 32'h002081B3, 32'h8000B083,
                                32'h00008067, 32'hFFFFF117, 32'h03F0909B, 32'h0000007F};
  logic [63:0] v_imm [12] = '{64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000, 64'd63, 64'd3,
                              64'hFFFFFFFFFFFFFFFC, 64'd8, 64'd0, 64'hFFFFFFFFFFFFF800,
                              64'd0, 64'hFFFFFFFFFFFFF000, 64'd31, 64'd0};
  logic [2:0]  v_fmt [12] = '{3'd3, 3'd4, 3'd6, 3'd6, 3'd2, 3'd5, 3'd0, 3'd1,
                              3'd1, 3'd4, 3'd6, 3'd0};
  logic        v_ill [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] instr, input logic [7:0] tag,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                      output int waited);
    exp_t e;
    logic done;
    done = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tag;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: tag 0x%0h in_ready=%0b required 1", tag, in_ready);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_imm", out_imm, prev.imm);
        chk("hold_fmt", out_fmt, prev.fmt);
        chk("hold_ill", out_illegal, prev.ill);
        chk("hold_tag", out_tag, prev.tag);
      end
      if (stale_watch && out_valid) begin
        chk("stale_tag", (out_tag == stale_a) || (out_tag == stale_b), 1'b0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got tag 0x%0h, required no output", out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("imm_tag%0h", mon_e.tag), out_imm, mon_e.imm);
          chk($sformatf("fmt_tag%0h", mon_e.tag), out_fmt, mon_e.fmt);
          chk($sformatf("ill_tag%0h", mon_e.tag), out_illegal, mon_e.ill);
          chk("order_tag", out_tag, mon_e.tag);
        end
        have_prev = 1'b0;
      end else if (out_valid) begin
        prev.imm = out_imm; prev.fmt = out_fmt; prev.ill = out_illegal; prev.tag = out_tag;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    v32 = 1'b0; instr32 = '0; tag32 = '0; ordy32 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_fmt", out_fmt, 3'd0);
    chk("rst_ill", out_illegal, 1'b0);
    chk("rst_tag", out_tag, 8'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_pre_edge", in_ready, 1'b0);
    @(negedge clk);
    chk("in_ready_post_edge", in_ready, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;

    // addi -1 with an empty output: result visible one cycle after transfer
    send(32'hFFF00093, 8'h01, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, w);
    @(negedge clk);
    chk("latency_1", out_valid, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      send(v_instr[i], 8'h10 + 8'(i), v_imm[i], v_fmt[i], v_ill[i], w);
      chk($sformatf("tput_wait_%0d", i), 64'(w), 64'd0);
    end
    drain();

    // Stall: two words fill output and skid, the third waits for release
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h00100093, 8'hA0, 64'd1, 3'd1, 1'b0, w);
    chk("stall_w0_wait", 64'(w), 64'd0);
    send(32'h00200093, 8'hA1, 64'd2, 3'd1, 1'b0, w);
    chk("stall_w1_wait", 64'(w), 64'd0);
    @(negedge clk);
    chk("skid_full_in_ready", in_ready, 1'b0);
    fork
      send(32'h00300093, 8'hA2, 64'd3, 3'd1, 1'b0, w);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    chk("stall_w2_waited", 64'(w > 0), 64'd1);
    drain();

    // Reset with the skid full: the held words must never appear
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h00400093, 8'hE1, 64'd4, 3'd1, 1'b0, w);
    send(32'h00500093, 8'hE2, 64'd5, 3'd1, 1'b0, w);
    @(negedge clk);
    chk("pre_reset_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    stale_a = 8'hE1; stale_b = 8'hE2; stale_watch = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_in_ready", in_ready, 1'b0);
    chk("rst2_tag", out_tag, 8'd0);
    @(negedge clk);
    chk("rst2_in_ready_back", in_ready, 1'b1);
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h123452B7, 8'h50, 64'h0000000012345000, 3'd4, 1'b0, w);
    send(32'h0000007F, 8'h51, 64'd0, 3'd0, 1'b1, w);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_out_valid", out_valid, 1'b0);

    // XLEN=32 instance: slli with shamt field 63 yields 31
    @(posedge clk); #1;
    v32 = 1'b1; instr32 = 32'h03F09093; tag32 = 8'h77;
    @(negedge clk);
    chk("x32_in_ready", rdy32, 1'b1);
    @(posedge clk); #1 v32 = 1'b0;
    @(negedge clk);
    chk("x32_valid", ov32, 1'b1);
    chk("x32_slli_imm", imm32, 32'd31);
    chk("x32_slli_fmt", fmt32, 3'd6);
    chk("x32_tag", otag32, 8'h77);
    @(posedge clk); #1;
    v32 = 1'b1; instr32 = 32'hFE000EE3; tag32 = 8'h78;
    @(posedge clk); #1 v32 = 1'b0;
    @(negedge clk);
    chk("x32_beq_imm", imm32, 32'hFFFFFFFC);
    chk("x32_beq_fmt", fmt32, 3'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 8, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, instruction word present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-007 SHALL have port in_instr, input, 32, RV instruction word.
REQ-008 SHALL have port in_tag, input, TAG_W, opaque sideband (e.g. PC index), passed unchanged.
REQ-009 SHALL have port out_valid, output, 1, decoded result present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result this cycle.
REQ-011 SHALL have port out_imm, output, XLEN, extended immediate.
REQ-012 SHALL have port out_fmt, output, 3, format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SH=6.
REQ-013 SHALL have port out_illegal, output, 1, opcode not in the supported set.
REQ-014 SHALL have port out_tag, output, TAG_W, in_tag of the same word.

Function
REQ-015 SHALL transfer in on in_valid & in_ready and out on out_valid & out_ready.
REQ-016 SHALL give a latency of exactly 1 cycle from input transfer to out_valid when the output is empty.
REQ-017 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-018 SHALL hold an output register plus a 1-entry skid buffer; in_ready SHALL be a registered signal equal to "skid empty".
REQ-019 SHALL, when out_ready is low and the output is full, capture the next accepted word in the skid and deassert in_ready the following cycle.
REQ-020 SHALL, on an output transfer with the skid full, move the skid into the output register the same edge and reassert in_ready the next cycle.
REQ-021 SHALL, on a simultaneous input and output transfer with the skid empty, load the new word directly into the output register.
REQ-022 SHALL hold out_imm, out_fmt, out_illegal and out_tag stable while out_valid & !out_ready.
REQ-023 SHALL deliver results in strict input order, with no loss and no duplication.
REQ-024 SHALL decode opcodes 0000011, 0010011 (except shifts), 0011011 (except shifts) and 1100111 as I: sext(instr[31:20]).
REQ-025 SHALL decode OP-IMM / OP-IMM-32 with funct3 001 or 101 as SH: zero-extended shamt.
  - shamt is instr[25:20] when XLEN=64 and opcode is 0010011.
  - shamt is instr[24:20] otherwise.
REQ-026 SHALL decode opcode 0100011 as S: sext({instr[31:25], instr[11:7]}).
REQ-027 SHALL decode opcode 1100011 as B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
REQ-028 SHALL decode opcodes 0110111 and 0010111 as U: sext({instr[31:12], 12'b0}).
REQ-029 SHALL decode opcode 1101111 as J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
REQ-030 SHALL decode opcode 0110011 as NONE with imm 0 and illegal 0.
REQ-031 SHALL decode any other opcode as NONE with imm 0 and illegal 1.
REQ-032 SHALL sign-extend from the top immediate bit to XLEN.

Reset
REQ-033 SHALL, while reset is high at a clock edge, clear out_valid, empty the skid, and drive out_imm=0, out_fmt=NONE, out_illegal=0, out_tag=0, in_ready=0.
REQ-034 SHALL assert in_ready on the first edge after reset deasserts.
REQ-035 SHALL discard any in-flight or skid data on reset mid-operation; no stale result SHALL appear afterwards.

Structure
REQ-036 SHALL place the format codes and opcode constants in shared package riscv_pkg.
REQ-037 SHALL implement decoding in a combinational sub-module imm_decode (instr to imm, fmt, illegal), instantiated once ahead of the registers.

Verification
REQ-038 SHALL cover: 0xFFF00093 (addi -1) -> out_imm=0xFFFFFFFFFFFFFFFF, fmt I, one cycle later.
REQ-039 SHALL cover: 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFFFFFFFFFC, fmt B; 0x123452B7 (lui) -> 0x0000000012345000, fmt U.
REQ-040 SHALL cover: 0x03F09093 (slli 63) -> out_imm=63, fmt SH for XLEN=64.
  - The same word with XLEN=32 -> out_imm=31.
REQ-041 SHALL cover: out_ready low, 3 words offered.
  - The first two are accepted and in_ready drops.
  - On releasing out_ready, the 3 results emerge in order with matching tags.
REQ-042 SHALL cover: 0x0000007F -> fmt NONE, illegal 1; reset asserted with skid full -> out_valid 0 next cycle, and no old tag is ever output.
